counter_bank: RTL and testbench

//  Bank of NUM_CH independent event counters with a shared runtime-programmable limit.

---
 rtl/counter_bank.sv | 128 ++++++++++++
 tb/tb_counter_bank.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/counter_bank.sv
// counter_bank: a bank of NUM_CH independent up/down event counters that share one
// runtime-programmable limit register. Each channel either saturates (WRAP = 0) or
// wraps (WRAP = 1) at the bounds 0 and limit. Each channel also drives a flag
// (count >= limit) and a registered terminal-count pulse.
// Optional feature: define COUNTER_BANK_OVF_EN to add the sticky per-channel ovf output.
module counter_bank #(
    parameter int NUM_CH  = 4,
    parameter int WIDTH   = 8,
    parameter int MAX_NUM = 100,
    parameter int WRAP    = 0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      cfg_we,
    input  logic [WIDTH-1:0]          cfg_limit,
    input  logic [NUM_CH-1:0]         clean,
    input  logic [NUM_CH-1:0]         load,
    input  logic [NUM_CH*WIDTH-1:0]   load_val,
    input  logic [NUM_CH-1:0]         en,
    input  logic [NUM_CH-1:0]         dir,
    output logic [NUM_CH*WIDTH-1:0]   count,
    output logic [NUM_CH-1:0]         flag,
    output logic [NUM_CH-1:0]         tc,
    output logic                      all_flag
`ifdef COUNTER_BANK_OVF_EN
    ,
    output logic [NUM_CH-1:0]         ovf
`endif
);

    logic [WIDTH-1:0]  limit_q;
    logic [WIDTH-1:0]  limit_d;
    logic [WIDTH-1:0]  count_q [NUM_CH];
    logic [WIDTH-1:0]  count_d [NUM_CH];
    logic [NUM_CH-1:0] tc_q;
    logic [NUM_CH-1:0] tc_d;
`ifdef COUNTER_BANK_OVF_EN
    logic [NUM_CH-1:0] ovf_q;
    logic [NUM_CH-1:0] ovf_d;
`endif

    // Next-state for the limit and every channel; channel updates compare against the current limit
    always_comb begin
        limit_d = cfg_we ? cfg_limit : limit_q;
        tc_d    = '0;
`ifdef COUNTER_BANK_OVF_EN
        ovf_d   = ovf_q;
`endif
        for (int i = 0; i < NUM_CH; i++) begin
            count_d[i] = count_q[i];
            if (clean[i]) begin
                count_d[i] = '0;
`ifdef COUNTER_BANK_OVF_EN
                ovf_d[i] = 1'b0;
`endif
            end else if (load[i]) begin
                count_d[i] = load_val[i*WIDTH +: WIDTH];
            end else if (en[i]) begin
                if (dir[i]) begin
                    if (count_q[i] < limit_q) begin
                        count_d[i] = count_q[i] + WIDTH'(1);
                        tc_d[i]    = (count_d[i] == limit_q);
                    end else begin
                        count_d[i] = (WRAP != 0) ? '0 : limit_q;
`ifdef COUNTER_BANK_OVF_EN
                        ovf_d[i] = 1'b1;
`endif
                    end
                end else begin
                    if (count_q[i] > limit_q) begin
                        count_d[i] = limit_q;
                    end else if (count_q[i] != '0) begin
                        count_d[i] = count_q[i] - WIDTH'(1);
                    end else begin
                        count_d[i] = (WRAP != 0) ? limit_q : '0;
`ifdef COUNTER_BANK_OVF_EN
                        ovf_d[i] = 1'b1;
`endif
                    end
                end
            end
        end
    end

    // State registers; reset restores the default limit and clears all channels
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            limit_q <= WIDTH'(MAX_NUM);
            tc_q    <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                count_q[i] <= '0;
            end
        end else begin
            limit_q <= limit_d;
            tc_q    <= tc_d;
            for (int i = 0; i < NUM_CH; i++) begin
                count_q[i] <= count_d[i];
            end
        end
    end

`ifdef COUNTER_BANK_OVF_EN
    // Sticky overflow register, cleared only by clean or reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= '0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`endif

    // Output packing and flag comparison straight from the registers
    always_comb begin
        count = '0;
        flag  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            count[i*WIDTH +: WIDTH] = count_q[i];
            flag[i]                 = (count_q[i] >= limit_q);
        end
    end

    assign tc       = tc_q;
    assign all_flag = &flag;

endmodule

// File: tb/tb_counter_bank.sv
// Self-checking bench for counter_bank: one saturating and one wrapping instance share
// the same stimulus and are compared every cycle against a behavioural model.
module tb_counter_bank;

    localparam int NUM_CH  = 4;
    localparam int WIDTH   = 8;
    localparam int MAX_NUM = 100;
    localparam int VW      = NUM_CH * WIDTH;

    logic              clk;
    logic              rst_n;
    logic              cfg_we;
    logic [WIDTH-1:0]  cfg_limit;
    logic [NUM_CH-1:0] clean;
    logic [NUM_CH-1:0] load;
    logic [VW-1:0]     load_val;
    logic [NUM_CH-1:0] en;
    logic [NUM_CH-1:0] dir;

    logic [VW-1:0]     count_o    [2];
    logic [NUM_CH-1:0] flag_o     [2];
    logic [NUM_CH-1:0] tc_o       [2];
    logic              all_flag_o [2];
    logic [NUM_CH-1:0] ovf_o      [2];

    int n_checks = 0;
    int n_fails  = 0;

    // Behavioural model: index 0 = saturating instance, 1 = wrapping instance
    int m_lim [2];
    int m_cnt [2][NUM_CH];
    bit m_tc  [2][NUM_CH];
    bit m_ovf [2][NUM_CH];

    counter_bank #(.NUM_CH(NUM_CH), .WIDTH(WIDTH), .MAX_NUM(MAX_NUM), .WRAP(0)) dut_sat (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_limit(cfg_limit),
        .clean(clean), .load(load), .load_val(load_val), .en(en), .dir(dir),
        .count(count_o[0]), .flag(flag_o[0]), .tc(tc_o[0]), .all_flag(all_flag_o[0])
`ifdef COUNTER_BANK_OVF_EN
        , .ovf(ovf_o[0])
`endif
    );

    counter_bank #(.NUM_CH(NUM_CH), .WIDTH(WIDTH), .MAX_NUM(MAX_NUM), .WRAP(1)) dut_wrap (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_limit(cfg_limit),
        .clean(clean), .load(load), .load_val(load_val), .en(en), .dir(dir),
        .count(count_o[1]), .flag(flag_o[1]), .tc(tc_o[1]), .all_flag(all_flag_o[1])
`ifdef COUNTER_BANK_OVF_EN
        , .ovf(ovf_o[1])
`endif
    );

`ifndef COUNTER_BANK_OVF_EN
    assign ovf_o[0] = '0;
    assign ovf_o[1] = '0;
`endif

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic modelReset();
        for (int k = 0; k < 2; k++) begin
            m_lim[k] = MAX_NUM;
            for (int c = 0; c < NUM_CH; c++) begin
                m_cnt[k][c] = 0;
                m_tc[k][c]  = 1'b0;
                m_ovf[k][c] = 1'b0;
            end
        end
    endtask

    // Apply the rules for one clock edge using the inputs currently driven
    task automatic modelStep();
        int old_v;
        int lim;
        for (int k = 0; k < 2; k++) begin
            lim = m_lim[k];
            for (int c = 0; c < NUM_CH; c++) begin
                old_v = m_cnt[k][c];
                m_tc[k][c] = 1'b0;
                if (clean[c]) begin
                    m_cnt[k][c] = 0;
                    m_ovf[k][c] = 1'b0;
                end else if (load[c]) begin
                    m_cnt[k][c] = int'(load_val[c*WIDTH +: WIDTH]);
                end else if (en[c] && dir[c]) begin
                    if (old_v < lim) begin
                        m_cnt[k][c] = old_v + 1;
                        m_tc[k][c]  = (old_v + 1 == lim);
                    end else begin
                        m_cnt[k][c] = (k == 1) ? 0 : lim;
                        m_ovf[k][c] = 1'b1;
                    end
                end else if (en[c]) begin
                    if (old_v > lim) begin
                        m_cnt[k][c] = lim;
                    end else if (old_v > 0) begin
                        m_cnt[k][c] = old_v - 1;
                    end else begin
                        m_cnt[k][c] = (k == 1) ? lim : 0;
                        m_ovf[k][c] = 1'b1;
                    end
                end
            end
            if (cfg_we) m_lim[k] = int'(cfg_limit);
        end
    endtask

    task automatic compareAll();
        logic [VW-1:0]     ec;
        logic [NUM_CH-1:0] ef, et, eo;
        logic              ea;
        for (int k = 0; k < 2; k++) begin
            ea = 1'b1;
            for (int c = 0; c < NUM_CH; c++) begin
                ec[c*WIDTH +: WIDTH] = WIDTH'(m_cnt[k][c]);
                ef[c] = (m_cnt[k][c] >= m_lim[k]);
                et[c] = m_tc[k][c];
                eo[c] = m_ovf[k][c];
                ea    = ea & ef[c];
            end
            checkOutput($sformatf("count_w%0d", k), 64'(count_o[k]), 64'(ec));
            checkOutput($sformatf("flag_w%0d", k), 64'(flag_o[k]), 64'(ef));
            checkOutput($sformatf("tc_w%0d", k), 64'(tc_o[k]), 64'(et));
            checkOutput($sformatf("all_flag_w%0d", k), 64'(all_flag_o[k]), 64'(ea));
`ifdef COUNTER_BANK_OVF_EN
            checkOutput($sformatf("ovf_w%0d", k), 64'(ovf_o[k]), 64'(eo));
`endif
        end
    endtask

    // Drive one cycle of inputs, clock it, update the model and compare
    task automatic applyStimulus(input logic we, input logic [WIDTH-1:0] lim,
                                 input logic [NUM_CH-1:0] cl, input logic [NUM_CH-1:0] ld,
                                 input logic [VW-1:0] lv, input logic [NUM_CH-1:0] e,
                                 input logic [NUM_CH-1:0] d);
        cfg_we    = we;
        cfg_limit = lim;
        clean     = cl;
        load      = ld;
        load_val  = lv;
        en        = e;
        dir       = d;
        @(posedge clk);
        modelStep();
        #1;
        compareAll();
    endtask

    // Asynchronous reset pulse placed mid-cycle, away from any clock edge
    task automatic midReset();
        @(negedge clk);
        rst_n = 1'b0;
        modelReset();
        #1;
        compareAll();
        checkOutput("rst_count_sat", 64'(count_o[0]), 64'd0);
        checkOutput("rst_flag_sat", 64'(flag_o[0]), 64'd0);
        #2;
        rst_n = 1'b1;
    endtask

    // Directed scenarios followed by a randomized phase
    initial begin
        int tc_pulses;
        logic [7:0] exp_seq [5];
        logic [VW-1:0] lv;
        exp_seq = '{8'd1, 8'd2, 8'd3, 8'd0, 8'd1};

        rst_n = 1'b0; cfg_we = 1'b0; cfg_limit = '0; clean = '0; load = '0;
        load_val = '0; en = '0; dir = '0;
        modelReset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        compareAll();
        rst_n = 1'b1;

        // Saturating up-count on ch0 past the default limit
        for (int i = 1; i <= 105; i++) begin
            applyStimulus(1'b0, '0, '0, '0, '0, 4'b0001, 4'b0001);
            checkOutput("t1_tc0", 64'(tc_o[0][0]), 64'(i == 100));
        end
        checkOutput("t1_count0", 64'(count_o[0][7:0]), 64'd100);
        checkOutput("t1_flag0", 64'(flag_o[0][0]), 64'd1);

        // Wrapping ch1 with limit 3
        applyStimulus(1'b1, 8'd3, '0, '0, '0, '0, '0);
        tc_pulses = 0;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, '0, '0, '0, '0, 4'b0010, 4'b0010);
            checkOutput("t2_seq", 64'(count_o[1][15:8]), 64'(exp_seq[i]));
            if (tc_o[1][1]) tc_pulses++;
        end
        checkOutput("t2_tc_once", 64'(tc_pulses), 64'd1);
        applyStimulus(1'b0, '0, '0, '0, '0, 4'b0010, 4'b0000);
        checkOutput("t2_down0", 64'(count_o[1][15:8]), 64'd0);
        applyStimulus(1'b0, '0, '0, '0, '0, 4'b0010, 4'b0000);
        checkOutput("t2_down_wrap", 64'(count_o[1][15:8]), 64'd3);

        // Lowered limit clamps a high count on the next up-step
        applyStimulus(1'b0, '0, '0, 4'b0100, 32'd50 << 16, '0, '0);
        applyStimulus(1'b1, 8'd10, '0, '0, '0, '0, '0);
        applyStimulus(1'b0, '0, '0, '0, '0, 4'b0100, 4'b0100);
        checkOutput("t3_clamp", 64'(count_o[0][23:16]), 64'd10);
        checkOutput("t3_flag2", 64'(flag_o[0][2]), 64'd1);
        checkOutput("t3_no_tc", 64'(tc_o[0][2]), 64'd0);

        // Priority clean > load > en on ch3
        applyStimulus(1'b0, '0, 4'b1000, 4'b1000, 32'd7 << 24, 4'b1000, 4'b1000);
        checkOutput("t4_clean_wins", 64'(count_o[0][31:24]), 64'd0);
        applyStimulus(1'b0, '0, '0, 4'b1000, 32'd7 << 24, 4'b1000, 4'b1000);
        checkOutput("t4_load_wins", 64'(count_o[0][31:24]), 64'd7);

        // all_flag
        applyStimulus(1'b0, '0, '0, 4'b1111, {4{8'd10}}, '0, '0);
        checkOutput("t5_all_set", 64'(all_flag_o[0]), 64'd1);
        applyStimulus(1'b0, '0, 4'b0001, '0, '0, '0, '0);
        checkOutput("t5_all_clr", 64'(all_flag_o[0]), 64'd0);

`ifdef COUNTER_BANK_OVF_EN
        // Sticky overflow behaviour
        applyStimulus(1'b0, '0, '0, 4'b0001, 32'd10, '0, '0);
        applyStimulus(1'b0, '0, '0, '0, '0, 4'b0001, 4'b0001);
        checkOutput("t6_ovf_set", 64'(ovf_o[0][0]), 64'd1);
        applyStimulus(1'b0, '0, '0, 4'b0001, 32'd2, '0, '0);
        checkOutput("t6_ovf_load", 64'(ovf_o[0][0]), 64'd1);
        applyStimulus(1'b0, '0, 4'b0001, '0, '0, '0, '0);
        checkOutput("t6_ovf_clean", 64'(ovf_o[0][0]), 64'd0);
`endif

        // Reset in the middle of counting, then resume against the default limit
        applyStimulus(1'b0, '0, '0, '0, '0, 4'b1111, 4'b1111);
        applyStimulus(1'b0, '0, '0, '0, '0, 4'b1111, 4'b1111);
        midReset();
        applyStimulus(1'b0, '0, '0, '0, '0, 4'b1111, 4'b1111);
        checkOutput("t6_resume", 64'(count_o[0][7:0]), 64'd1);

        // Randomized phase, biased towards small limits to reach the bounds often
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                midReset();
            end
            for (int c = 0; c < NUM_CH; c++) begin
                lv[c*WIDTH +: WIDTH] = ($urandom_range(0, 3) == 0) ? WIDTH'($urandom)
                                                                   : WIDTH'($urandom_range(0, 12));
            end
            applyStimulus(($urandom_range(0, 15) == 0),
                          ($urandom_range(0, 7) == 0) ? WIDTH'($urandom) : WIDTH'($urandom_range(0, 10)),
                          NUM_CH'($urandom & $urandom & $urandom & $urandom),
                          NUM_CH'($urandom & $urandom & $urandom),
                          lv,
                          NUM_CH'($urandom | $urandom),
                          NUM_CH'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
